// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: board front end for a combinational ALU slice.
// Operand A and then operand B are loaded from the switches, one button press each.
// The block then holds both operands on the ALU for a settle time and captures
// the ALU result and its Z/N/C/V flags for the display logic.
module alu_op_sequencer #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             result_valid,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  // Index of the last settle cycle; capture happens on the edge where cnt reaches it.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             prev_r;
  logic             press_s;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r, a_nxt_s;
  logic [WIDTH-1:0] b_r, b_nxt_s;
  logic [3:0]       cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] result_r, result_nxt_s;
  logic [3:0]       flags_r, flags_nxt_s;
  logic             valid_r, valid_nxt_s;

  // Synchronise the raw button and keep one cycle of history. Reset loads ones so
  // a button already held down yields no press until it is released and pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= btn_enter;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // One-cycle pulse for each rising edge of the synchronised button.
  assign press_s = sync2_r & ~prev_r;

  // State and datapath registers; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_A;
      a_r      <= '0;
      b_r      <= '0;
      cnt_r    <= 4'd0;
      result_r <= '0;
      flags_r  <= 4'd0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      a_r      <= a_nxt_s;
      b_r      <= b_nxt_s;
      cnt_r    <= cnt_nxt_s;
      result_r <= result_nxt_s;
      flags_r  <= flags_nxt_s;
      valid_r  <= valid_nxt_s;
    end
  end

  // Next-state and next-datapath logic; every register holds unless its state changes it.
  always_comb begin
    state_nxt_s  = state_r;
    a_nxt_s      = a_r;
    b_nxt_s      = b_r;
    cnt_nxt_s    = cnt_r;
    result_nxt_s = result_r;
    flags_nxt_s  = flags_r;
    valid_nxt_s  = valid_r;
    case (state_r)
      S_A: begin
        if (press_s) begin
          a_nxt_s     = sw;
          state_nxt_s = S_B;
        end else begin
          state_nxt_s = S_A;
        end
      end
      S_B: begin
        if (press_s) begin
          b_nxt_s     = sw;
          cnt_nxt_s   = 4'd0;
          state_nxt_s = S_EXEC;
        end else begin
          state_nxt_s = S_B;
        end
      end
      S_EXEC: begin
        // Presses are ignored here; the counter stops at CNT_LAST so it never wraps.
        if (cnt_r == CNT_LAST) begin
          result_nxt_s = alu_r;
          flags_nxt_s  = {alu_z, alu_n, alu_c, alu_v};
          valid_nxt_s  = 1'b1;
          state_nxt_s  = S_SHOW;
        end else begin
          cnt_nxt_s    = cnt_r + 4'd1;
          state_nxt_s  = S_EXEC;
        end
      end
      S_SHOW: begin
        if (press_s) begin
          valid_nxt_s = 1'b0;
          state_nxt_s = S_A;
        end else begin
          state_nxt_s = S_SHOW;
        end
      end
      default: begin
        state_nxt_s = S_A;
      end
    endcase
  end

  assign alu_a        = a_r;
  assign alu_b        = b_r;
  assign result       = result_r;
  assign flags        = flags_r;
  assign result_valid = valid_r;
  assign state        = state_r;

endmodule
